// File: rtl/alu_exec_unit.sv
// EX-stage execution unit. Add, sub, and, or and the reserved code finish in one
// cycle. sll/sllv/srav shift through a 1-bit-per-cycle serial shifter.
// Valid/ready handshakes on both sides let the pipeline stall while a shift runs.
module alu_exec_unit #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_sel,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic [SHW-1:0]   shamt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ovf,
  output logic             illegal
);

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_ADD  = 3'b010,
    OP_SLLV = 3'b011,
    OP_SRAV = 3'b100,
    OP_RSVD = 3'b101,
    OP_SUB  = 3'b110,
    OP_SLL  = 3'b111
  } op_e;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_e;

  state_e           r_state;
  logic [WIDTH-1:0] r_acc;
  logic [SHW-1:0]   r_cnt;
  logic             r_right;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_ovf;
  logic             r_illegal;
  logic             r_valid;

  op_e              w_op;
  logic             w_accept;
  logic [WIDTH-1:0] w_b_eff;
  logic [WIDTH-1:0] w_sum;
  logic             w_sum_ovf;
  logic [SHW-1:0]   w_cnt;
  logic             w_is_shift;
  logic [WIDTH-1:0] w_res1;
  logic             w_ovf1;
  logic             w_ill1;
  logic [WIDTH-1:0] w_acc_next;

  assign w_op     = op_e'(alu_sel);
  assign in_ready = (r_state == S_IDLE) || ((r_state == S_DONE) && out_ready);
  assign w_accept = in_valid && in_ready;

  // Subtraction is an add of the two's complement; overflow uses that same operand.
  assign w_b_eff   = (w_op == OP_SUB) ? (~src_b + WIDTH'(1)) : src_b;
  assign w_sum     = src_a + w_b_eff;
  assign w_sum_ovf = (src_a[WIDTH-1] == w_b_eff[WIDTH-1]) &&
                     (w_sum[WIDTH-1] != src_a[WIDTH-1]);

  // sll takes its count from shamt; the variable shifts use the low bits of rs.
  assign w_cnt = (w_op == OP_SLL) ? shamt : src_a[SHW-1:0];

  // One serial shift step on the accumulator.
  assign w_acc_next = r_right ? {r_acc[WIDTH-1], r_acc[WIDTH-1:1]}
                              : {r_acc[WIDTH-2:0], 1'b0};

  // Single-cycle result; a zero-count shift passes src_b straight through.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    w_res1     = '0;
    w_ovf1     = 1'b0;
    w_ill1     = 1'b0;
    w_is_shift = 1'b0;
    case (w_op)
      OP_ADD, OP_SUB: begin
        w_res1 = w_sum;
        w_ovf1 = w_sum_ovf;
      end
      OP_AND: w_res1 = src_a & src_b;
      OP_OR:  w_res1 = src_a | src_b;
      OP_SLL, OP_SLLV, OP_SRAV: begin
        w_res1     = src_b;
        w_is_shift = 1'b1;
      end
      default: w_ill1 = 1'b1;
    endcase
  end

  // Control FSM plus the shift datapath and registered outputs.
  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments so every register sees pre-edge values.
    if (reset) begin
      r_state   <= S_IDLE;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_right   <= 1'b0;
      r_result  <= '0;
      r_zero    <= 1'b0;
      r_ovf     <= 1'b0;
      r_illegal <= 1'b0;
      r_valid   <= 1'b0;
    end else if (w_accept) begin
      // Accept only happens from IDLE or from DONE with a handshake.
      if (w_is_shift && (w_cnt != '0)) begin
        r_state   <= S_SHIFT;
        r_acc     <= src_b;
        r_cnt     <= w_cnt;
        r_right   <= (w_op == OP_SRAV);
        r_valid   <= 1'b0;
        r_ovf     <= 1'b0;
        r_illegal <= 1'b0;
      end else begin
        r_state   <= S_DONE;
        r_result  <= w_res1;
        r_zero    <= (w_res1 == '0);
        r_ovf     <= w_ovf1;
        r_illegal <= w_ill1;
        r_valid   <= 1'b1;
      end
    end else begin
      case (r_state)
        S_SHIFT: begin
          r_acc <= w_acc_next;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == SHW'(1)) begin
            r_state  <= S_DONE;
            r_result <= w_acc_next;
            r_zero   <= (w_acc_next == '0);
            r_valid  <= 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state   <= S_IDLE;
            r_valid   <= 1'b0;
            r_illegal <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_valid = r_valid;
  assign result    = r_result;
  assign zero      = r_zero;
  assign ovf       = r_ovf;
  assign illegal   = r_illegal;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed scenarios followed by random
// operations, each compared against a behavioural reference model.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  alu_sel = 3'b000;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic [4:0]  shamt = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        zero;
  logic        ovf;
  logic        illegal;

  int n_checks = 0;
  int n_errors = 0;

  alu_exec_unit #(.WIDTH(32), .SHW(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_sel   (alu_sel),
    .src_a     (src_a),
    .src_b     (src_b),
    .shamt     (shamt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .ovf       (ovf),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: result, flags and latency straight from the operation's rules.
  function automatic void model(input logic [2:0] sel, input logic [31:0] a,
                                input logic [31:0] b, input logic [4:0] sh,
                                output logic [31:0] r, output logic ov,
                                output logic il, output int lat);
    logic [31:0] bp;
    int n;
    r = '0; ov = 1'b0; il = 1'b0; lat = 1;
    case (sel)
      3'b010, 3'b110: begin
        bp = (sel == 3'b110) ? -b : b;
        r  = a + bp;
        ov = (a[31] == bp[31]) && (r[31] != a[31]);
      end
      3'b000: r = a & b;
      3'b001: r = a | b;
      3'b111, 3'b011, 3'b100: begin
        n   = (sel == 3'b111) ? int'(sh) : int'(a % 32);
        r   = (sel == 3'b100) ? 32'($signed(b) >>> n) : (b << n);
        lat = 1 + n;
      end
      default: il = 1'b1;
    endcase
  endfunction

  // Issue one op at a negedge, wait for its result, check it. With ordy=0 the
  // result is held in DONE for 3 cycles first. Returns at a negedge with
  // out_valid expected high and out_ready=1.
  task automatic do_op(input logic [2:0] sel, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh, input bit ordy);
    logic [31:0] er;
    logic        eo, ei;
    int          el, lat, busy;
    model(sel, a, b, sh, er, eo, ei, el);
    alu_sel = sel; src_a = a; src_b = b; shamt = sh;
    in_valid = 1'b1; out_ready = 1'b1;
    #1;
    check("in_ready_at_issue", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0; out_ready = ordy;
    alu_sel = 3'($urandom); src_a = $urandom; src_b = $urandom; shamt = 5'($urandom);
    @(negedge clk);
    lat = 1; busy = 0;
    while (!out_valid && lat < 80) begin
      if (!in_ready) busy++;
      @(negedge clk);
      lat++;
    end
    check("latency", 32'(lat), 32'(el));
    check("busy_cycles", 32'(busy), 32'(el - 1));
    check("result", result, er);
    check("zero", 32'(zero), 32'(er == 32'd0));
    check("ovf", 32'(ovf), 32'(eo));
    check("illegal", 32'(illegal), 32'(ei));
    if (!ordy) begin
      repeat (3) begin
        @(negedge clk);
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_result", result, er);
        check("hold_in_ready", 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
    end
  endtask

  // Let the pending result handshake with nothing new behind it.
  task automatic drain();
    in_valid = 1'b0;
    @(negedge clk);
    check("valid_after_hs", 32'(out_valid), 32'd0);
  endtask

  initial begin
    logic [2:0]  sel;
    logic [31:0] a, b;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_zero", 32'(zero), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    do_op(3'b010, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0, 1'b1);
    drain();
    do_op(3'b110, 32'd5, 32'd5, 5'd0, 1'b1);
    do_op(3'b000, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd0, 1'b1);
    drain();
    do_op(3'b110, 32'h0000_0000, 32'h8000_0000, 5'd0, 1'b1);
    drain();
    do_op(3'b100, 32'h0000_001F, 32'h8000_0000, 5'd0, 1'b1);
    drain();
    do_op(3'b111, 32'hFFFF_FFFF, 32'h0000_1234, 5'd0, 1'b1);
    do_op(3'b011, 32'h0000_0024, 32'h0000_0001, 5'd0, 1'b1);
    drain();
    do_op(3'b001, 32'h1234_0000, 32'h0000_5678, 5'd0, 1'b0);
    drain();

    // Reset during a 10-bit sllv discards the operation.
    alu_sel = 3'b011; src_a = 32'd10; src_b = 32'h0000_0003; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_result", result, 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    do_op(3'b011, 32'd10, 32'h0000_0003, 5'd0, 1'b1);
    drain();
    do_op(3'b101, 32'h1111_1111, 32'h2222_2222, 5'd0, 1'b1);
    drain();

    for (int i = 0; i < 80; i++) begin
      sel = 3'($urandom);
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: a = 32'h7FFF_FFFF;
        1: b = 32'h8000_0000;
        2: b = a;
        default: ;
      endcase
      do_op(sel, a, b, 5'($urandom), ($urandom_range(0, 3) != 0));
      if ($urandom_range(0, 1) == 0) drain();
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
